ps2_kbd_rx: RTL
===============

Name: ps2_kbd_rx

Overview:
- Receiving end of the PS/2 keyboard serial stream that hps_io emits on ps2_kbd_clk_out/ps2_kbd_data_out.
- Deserialises 11-bit device-to-host frames, checks framing and parity, and folds E0/F0 prefixes into an 11-bit key event in ps2_key format.
- Sits inside the CoCo3 core in front of the keyboard matrix logic.

Parameters:
- CLK_FILTER, 4, consecutive identical synchronised samples required before the filtered PS/2 clock changes state.
- TIMEOUT_CYCLES, 50000, clk_sys cycles without a filtered clock edge before a partial frame is aborted.

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ps2_clk  in  1  PS/2 clock from hps_io, asynchronous, idle high.
- ps2_data  in  1  PS/2 data from hps_io, asynchronous, idle high.
- code  out  8  last good scan byte.
- code_valid  out  1  one-cycle pulse when code updates.
- parity_err  out  1  one-cycle pulse on a parity failure.
- frame_err  out  1  one-cycle pulse on bad start bit, bad stop bit or timeout.
- key_event  out  11  [10] toggle, [9] pressed, [8] extended, [7:0] scan code.
- key_strobe  out  1  one-cycle pulse when key_event updates.

Behaviour:
- Reset values:
  - All outputs 0.
  - Synchroniser stages and filtered clock = 1.
  - Bit counter 0, timeout counter 0, state IDLE, ext/brk pending flags 0.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-FF synchroniser.
  - A filter counter changes the filtered clock only after CLK_FILTER consecutive synchronised samples differ from it.
  - A falling edge is the cycle the filtered clock goes 1 -> 0. Data is sampled from the synchronised ps2_data in that cycle.
- Frame FSM (IDLE, RECV, CHECK):
  - IDLE: on a falling edge, sample the start bit.
    - Sample 0: go to RECV with bit counter = 1.
    - Sample 1: pulse frame_err and stay in IDLE.
  - RECV: each falling edge shifts one bit in, LSB first. Order is 8 data bits, then odd parity, then stop. The counter increments per edge. After the stop bit (counter = 10), go to CHECK.
  - CHECK (one cycle), then return to IDLE:
    - Stop bit 0: frame_err.
    - Else XOR of the 8 data bits and the parity bit equals 0: parity_err.
    - Else: code = byte and code_valid = 1.
  - Latency: code_valid is asserted 2 cycles after the filtered falling edge of the stop bit (edge cycle -> CHECK -> registered output).
- Timeout:
  - In RECV, the timeout counter clears on every filtered falling edge and increments otherwise.
  - When it reaches TIMEOUT_CYCLES-1: pulse frame_err, go to IDLE, discard partial bits.
  - The counter is held at 0 in IDLE.
- Prefix decoder (acts in the cycle after code_valid):
  - code E0: set ext pending; no key_strobe.
  - code F0: set brk pending; no key_strobe.
  - Any other code: key_event <= {~key_event[10], ~brk, ext, code}, key_strobe = 1, then clear both pending flags.
  - Repeated E0 or F0 simply keeps the flag set.
  - parity_err or frame_err clears both pending flags.
- Simultaneous events: a falling edge arriving during CHECK is treated as a start bit (CHECK behaves as IDLE for edge capture).
- Reset mid-frame: returns to reset values immediately. key_event toggle goes to 0.

Test Plan:
- Valid frame 0x1C (start 0, data LSB-first, parity 0, stop 1), ~12.5 kHz bit clock -> code_valid, code=0x1C; next cycle key_strobe, key_event=0x61C.
- Frames F0, 1C after the above -> one key_strobe only, key_event=0x01C (toggle 0, released). Then E0, 75 -> key_event=0x775.
- Frame 0x1C with parity bit 1 -> parity_err pulse, no code_valid, no key_strobe. Preceding F0 pending is cleared, so a following 0x1C gives key_event[9]=1.
- Glitches:
  - A low pulse of CLK_FILTER-1 cycles on ps2_clk while idle -> no state change and no error.
  - A low pulse of CLK_FILTER cycles with ps2_data=1 -> frame_err (bad start bit).
- Five bits sent, then lines idle for TIMEOUT_CYCLES -> frame_err pulse exactly at count TIMEOUT_CYCLES-1. A subsequent full 0x29 frame decodes to code=0x29 and key_event=0x629.
- Assert reset for 1 cycle after the 6th bit -> all outputs 0. A following 0x1C frame decodes cleanly with key_event=0x61C.

Source files
------------

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronise and filter the PS/2 lines, deserialise
// 11-bit frames, and fold E0/F0 prefixes into an 11-bit key event.
module ps2_kbd_rx #(
  parameter int CLK_FILTER     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [7:0]  code,
  output logic        code_valid,
  output logic        parity_err,
  output logic        frame_err,
  output logic [10:0] key_event,
  output logic        key_strobe
);
  localparam int FW = $clog2(CLK_FILTER + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

  state_t          state, state_n;
  logic            clk_s1, clk_s2, dat_s1, dat_s2;
  logic            filt, filt_q, fall;
  logic [FW-1:0]   flt_cnt;
  logic [3:0]      bit_cnt;
  logic [9:0]      sr;
  logic [TW-1:0]   to_cnt;
  logic            timeout, start_ok, start_bad;
  logic            cv_n, perr_n, ferr_n;
  logic            ext, brk;

  // Filtered clock only moves after CLK_FILTER consecutive disagreeing samples
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      dat_s1  <= 1'b1;
      dat_s2  <= 1'b1;
      filt    <= 1'b1;
      filt_q  <= 1'b1;
      flt_cnt <= '0;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
      filt_q <= filt;
      if (clk_s2 != filt) begin
        if (flt_cnt == FW'(CLK_FILTER - 1)) begin
          filt    <= clk_s2;
          flt_cnt <= '0;
        end else begin
          flt_cnt <= flt_cnt + FW'(1);
        end
      end else begin
        flt_cnt <= '0;
      end
    end
  end

  assign fall      = filt_q & ~filt;
  assign timeout   = (state == RECV) && !fall && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
  // CHECK lasts one cycle and captures a start bit exactly like IDLE
  assign start_ok  = (state != RECV) && fall && !dat_s2;
  assign start_bad = (state != RECV) && fall && dat_s2;

  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, CHECK: state_n = start_ok ? RECV : IDLE;
      RECV: begin
        if (fall && bit_cnt == 4'd10) state_n = CHECK;
        else if (timeout)             state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // sr[7:0] data, sr[8] parity, sr[9] stop once the frame is complete
  always_comb begin
    cv_n   = 1'b0;
    perr_n = 1'b0;
    ferr_n = start_bad | timeout;
    if (state == CHECK) begin
      if (!sr[9])           ferr_n = 1'b1;
      else if (!(^sr[8:0])) perr_n = 1'b1;
      else                  cv_n   = 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      bit_cnt <= '0;
      sr      <= '0;
      to_cnt  <= '0;
    end else begin
      if (start_ok) begin
        bit_cnt <= 4'd1;
        sr      <= '0;
      end else if (state == RECV && fall) begin
        bit_cnt <= bit_cnt + 4'd1;
        sr      <= {dat_s2, sr[9:1]};
      end
      to_cnt <= (state == RECV && !fall && !timeout) ? to_cnt + TW'(1) : '0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      code       <= '0;
      code_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      key_event  <= '0;
      key_strobe <= 1'b0;
      ext        <= 1'b0;
      brk        <= 1'b0;
    end else begin
      code_valid <= cv_n;
      parity_err <= perr_n;
      frame_err  <= ferr_n;
      if (cv_n) code <= sr[7:0];
      key_strobe <= 1'b0;
      if (code_valid) begin
        if (code == 8'hE0)      ext <= 1'b1;
        else if (code == 8'hF0) brk <= 1'b1;
        else begin
          key_event  <= {~key_event[10], ~brk, ext, code};
          key_strobe <= 1'b1;
          ext        <= 1'b0;
          brk        <= 1'b0;
        end
      end
      if (parity_err || frame_err) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end
    end
  end
endmodule
